// File: rtl/async_fifo_lvl_pkg.sv
// Shared helpers for async_fifo_lvl: Gray/binary conversion and occupancy arithmetic.
// The helpers take zero-extended PTR_MAXW-bit values and callers cast the result back to their own width.
package async_fifo_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int PTR_MAXW        = 32;

    typedef logic [PTR_MAXW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = {PTR_MAXW{1'b0}};
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int i = PTR_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Truncating the difference to the caller's pointer width gives the modulo occupancy.
    function automatic ptr_t fifo_level(input ptr_t ahead, input ptr_t behind);
        return ahead - behind;
    endfunction

endpackage

// File: rtl/async_fifo_lvl_sync.sv
// N-stage synchroniser with asynchronous active-low reset.
// Used for both Gray pointer crossings and both reset-release synchronisers.
module afifo_sync_n #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain; the last stage is the synchronised output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with per-domain fill levels, almost flags and registered read data.
// Define ASYNC_FIFO_ERR_EN to build the sticky woverflow/runderflow flags.
module async_fifo_lvl
    import async_fifo_pkg::*;
#(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int AFULL_TH    = (2**ASIZE) - 2,
    parameter int AEMPTY_TH   = 2
) (
    input  logic             wclk,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    input  logic             wclr_err,
    output logic             woverflow,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel,
    input  logic             rclr_err,
    output logic             runderflow
);

    localparam int             PW       = ASIZE + 1;
    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = PW'(AEMPTY_TH);

    logic             wrst_n_s, rrst_n_s;
    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0] wbin_q, wbin_d, wgray_q, wgray_d, wq_rptr_s, wlevel_q, wlevel_d;
    logic           wfull_q, wfull_d, walmost_full_q, walmost_full_d, winc_ok_s;

    logic [ASIZE:0]   rbin_q, rbin_d, rgray_q, rgray_d, rq_wptr_s, rlevel_q, rlevel_d;
    logic             rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d, rinc_ok_s;
    logic             rvalid_q, rvalid_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;

    afifo_sync_n #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_wrst_sync (
        .clk_i(wclk), .rst_n_i(rrst_n), .d_i(1'b1), .q_o(wrst_n_s)
    );

    afifo_sync_n #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rrst_sync (
        .clk_i(rclk), .rst_n_i(rrst_n), .d_i(1'b1), .q_o(rrst_n_s)
    );

    afifo_sync_n #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk_i(wclk), .rst_n_i(wrst_n_s), .d_i(rgray_q), .q_o(wq_rptr_s)
    );

    afifo_sync_n #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk_i(rclk), .rst_n_i(rrst_n_s), .d_i(wgray_q), .q_o(rq_wptr_s)
    );

    // Write-side next state: pointer, full test against the synchronised read pointer, level.
    always_comb begin
        winc_ok_s      = winc & ~wfull_q & wrst_n_s;
        wbin_d         = wbin_q + {{ASIZE{1'b0}}, winc_ok_s};
        wgray_d        = PW'(bin2gray(PTR_MAXW'(wbin_d)));
        wfull_d        = (wgray_d == {~wq_rptr_s[ASIZE:ASIZE-1], wq_rptr_s[ASIZE-2:0]});
        wlevel_d       = PW'(fifo_level(PTR_MAXW'(wbin_d), gray2bin(PTR_MAXW'(wq_rptr_s))));
        walmost_full_d = (wlevel_d >= AFULL_C);
    end

    // Write-side state registers.
    always_ff @(posedge wclk or negedge wrst_n_s) begin
        if (!wrst_n_s) begin
            wbin_q         <= {PW{1'b0}};
            wgray_q        <= {PW{1'b0}};
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= {PW{1'b0}};
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
        end
    end

    // Storage array; deliberately unreset.
    always_ff @(posedge wclk) begin
        if (winc_ok_s) begin
            mem_q[wbin_q[ASIZE-1:0]] <= wdata;
        end
    end

    // Read-side next state: pointer, empty test, level and registered read data.
    always_comb begin
        rinc_ok_s       = rinc & ~rempty_q & rrst_n_s;
        rbin_d          = rbin_q + {{ASIZE{1'b0}}, rinc_ok_s};
        rgray_d         = PW'(bin2gray(PTR_MAXW'(rbin_d)));
        rempty_d        = (rgray_d == rq_wptr_s);
        rlevel_d        = PW'(fifo_level(gray2bin(PTR_MAXW'(rq_wptr_s)), PTR_MAXW'(rbin_d)));
        ralmost_empty_d = (rlevel_d <= AEMPTY_C);
        rvalid_d        = rinc_ok_s;
        if (rinc_ok_s) begin
            rdata_d = mem_q[rbin_q[ASIZE-1:0]];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read-side state registers.
    always_ff @(posedge rclk or negedge rrst_n_s) begin
        if (!rrst_n_s) begin
            rbin_q          <= {PW{1'b0}};
            rgray_q         <= {PW{1'b0}};
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rlevel_q        <= {PW{1'b0}};
            rvalid_q        <= 1'b0;
            rdata_q         <= {DSIZE{1'b0}};
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rlevel_q        <= rlevel_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
        end
    end

`ifdef ASYNC_FIFO_ERR_EN
    logic woverflow_q, woverflow_d, runderflow_q, runderflow_d;

    // Sticky error next state; a new error wins over a same-cycle clear.
    always_comb begin
        if (winc & wfull_q) begin
            woverflow_d = 1'b1;
        end else if (wclr_err) begin
            woverflow_d = 1'b0;
        end else begin
            woverflow_d = woverflow_q;
        end
        if (rinc & rempty_q) begin
            runderflow_d = 1'b1;
        end else if (rclr_err) begin
            runderflow_d = 1'b0;
        end else begin
            runderflow_d = runderflow_q;
        end
    end

    // Overflow flag lives in the write domain.
    always_ff @(posedge wclk or negedge wrst_n_s) begin
        if (!wrst_n_s) begin
            woverflow_q <= 1'b0;
        end else begin
            woverflow_q <= woverflow_d;
        end
    end

    // Underflow flag lives in the read domain.
    always_ff @(posedge rclk or negedge rrst_n_s) begin
        if (!rrst_n_s) begin
            runderflow_q <= 1'b0;
        end else begin
            runderflow_q <= runderflow_d;
        end
    end

    assign woverflow  = woverflow_q;
    assign runderflow = runderflow_q;
`else
    logic unused_err_s;
    assign unused_err_s = wclr_err ^ rclr_err;
    assign woverflow    = 1'b0;
    assign runderflow   = 1'b0;
`endif

    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign wlevel        = wlevel_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;
    assign rvalid        = rvalid_q;
    assign rdata         = rdata_q;

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Directed bench for async_fifo_lvl: reset, latency, fill, drain, mid-run reset, randomised CDC traffic.
// Error-flag expectations follow whether ASYNC_FIFO_ERR_EN is defined.
module tb_async_fifo_lvl;

`ifdef ASYNC_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       wclk = 1'b0;
    logic       rclk = 1'b0;
    logic       rrst_n, winc, rinc, wclr_err, rclr_err;
    logic [7:0] wdata;
    logic       wfull, walmost_full, woverflow, rvalid, rempty, ralmost_empty, runderflow;
    logic [4:0] wlevel, rlevel;
    logic [7:0] rdata;

    int wper = 10;
    int rper = 10;
    int checks = 0;
    int failures = 0;

    // Write clock generator.
    always begin
        wclk = 1'b0;
        #(wper / 2);
        wclk = 1'b1;
        #(wper - wper / 2);
    end

    // Read clock generator.
    always begin
        rclk = 1'b0;
        #(rper / 2);
        rclk = 1'b1;
        #(rper - rper / 2);
    end

    async_fifo_lvl #(
        .DSIZE(8), .ASIZE(4), .SYNC_STAGES(2), .AFULL_TH(14), .AEMPTY_TH(2)
    ) dut (
        .wclk(wclk), .rclk(rclk), .rrst_n(rrst_n),
        .wdata(wdata), .winc(winc), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .wclr_err(wclr_err), .woverflow(woverflow),
        .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .rlevel(rlevel), .rclr_err(rclr_err),
        .runderflow(runderflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rlevel(input string tag, input int lvl, input int budget);
        int c = 0;
        while (32'(rlevel) != lvl && c < budget) begin
            @(negedge rclk);
            c++;
        end
        check(tag, 32'(rlevel), 32'(lvl));
    endtask

    task automatic wait_wlevel(input string tag, input int lvl, input int budget);
        int c = 0;
        while (32'(wlevel) != lvl && c < budget) begin
            @(negedge wclk);
            c++;
        end
        check(tag, 32'(wlevel), 32'(lvl));
    endtask

    task automatic clear_errors();
        @(negedge wclk);
        wclr_err = 1'b1;
        @(negedge wclk);
        wclr_err = 1'b0;
        @(negedge rclk);
        rclr_err = 1'b1;
        @(negedge rclk);
        rclr_err = 1'b0;
    endtask

    task automatic run_random(input int n);
        logic [7:0] q[$];
        int nw = 0;
        int nr = 0;
        fork
            begin
                int cyc = 0;
                while (nw < n && cyc < 5000) begin
                    @(negedge wclk);
                    cyc++;
                    if ($urandom_range(0, 3) != 0) begin
                        wdata = 8'($urandom);
                        winc  = 1'b1;
                        if (!wfull) begin
                            q.push_back(wdata);
                            nw++;
                        end
                    end else begin
                        winc = 1'b0;
                    end
                end
                @(negedge wclk);
                winc = 1'b0;
            end
            begin
                int cyc = 0;
                logic [7:0] exp_d;
                while (nr < n && cyc < 8000) begin
                    @(negedge rclk);
                    cyc++;
                    rinc = ($urandom_range(0, 2) != 0);
                    if (rinc && !rempty) begin
                        @(posedge rclk);
                        #1;
                        exp_d = (q.size() > 0) ? q.pop_front() : 8'h00;
                        check("rand_rvalid", 32'(rvalid), 32'(1'b1));
                        check("rand_rdata", 32'(rdata), 32'(exp_d));
                        nr++;
                    end
                end
                rinc = 1'b0;
            end
        join
        check("rand_read_count", 32'(nr), 32'(n));
        check("rand_leftover", 32'(q.size()), 32'(0));
        repeat (8) @(negedge rclk);
        check("rand_final_empty", 32'(rempty), 32'(1'b1));
        clear_errors();
    endtask

    // Directed stimulus sequence.
    initial begin
        winc = 1'b0; rinc = 1'b0; wdata = 8'h00; wclr_err = 1'b0; rclr_err = 1'b0;
        rrst_n = 1'b0;

        // Reset: requests during and just after reset release are ignored.
        repeat (2) @(negedge wclk);
        winc = 1'b1; wdata = 8'h11; rinc = 1'b1;
        repeat (3) @(negedge wclk);
        winc = 1'b0; rinc = 1'b0;
        check("rst_wfull", 32'(wfull), 32'(1'b0));
        check("rst_walmost_full", 32'(walmost_full), 32'(1'b0));
        check("rst_wlevel", 32'(wlevel), 32'(5'd0));
        check("rst_woverflow", 32'(woverflow), 32'(1'b0));
        check("rst_rempty", 32'(rempty), 32'(1'b1));
        check("rst_ralmost_empty", 32'(ralmost_empty), 32'(1'b1));
        check("rst_rlevel", 32'(rlevel), 32'(5'd0));
        check("rst_rdata", 32'(rdata), 32'(8'h00));
        check("rst_rvalid", 32'(rvalid), 32'(1'b0));
        check("rst_runderflow", 32'(runderflow), 32'(1'b0));
        @(negedge wclk);
        rrst_n = 1'b1; winc = 1'b1;
        @(negedge wclk);
        winc = 1'b0;
        repeat (4) @(negedge wclk);
        check("rst_release_wlevel", 32'(wlevel), 32'(5'd0));
        check("rst_release_rempty", 32'(rempty), 32'(1'b1));

        // Latency with in-phase equal clocks.
        @(negedge wclk);
        wdata = 8'h3C; winc = 1'b1;
        @(posedge wclk);
        #1;
        winc = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge rclk);
            #1;
            check("lat_rempty", 32'(rempty), 32'(k < 3));
        end
        check("lat_rlevel", 32'(rlevel), 32'(5'd1));
        @(negedge rclk);
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
        check("lat_rdata", 32'(rdata), 32'(8'h3C));
        check("lat_rvalid", 32'(rvalid), 32'(1'b1));
        @(posedge rclk);
        #1;
        check("lat_rvalid_drop", 32'(rvalid), 32'(1'b0));

        // Fill.
        wait_wlevel("fill_start_wlevel", 0, 20);
        for (int i = 0; i < 16; i++) begin
            @(negedge wclk);
            wdata = 8'(i); winc = 1'b1;
            @(posedge wclk);
            #1;
            if (i >= 12) check("fill_walmost_full", 32'(walmost_full), 32'(i >= 13));
            if (i >= 14) check("fill_wfull", 32'(wfull), 32'(i == 15));
        end
        check("fill_wlevel", 32'(wlevel), 32'(5'd16));
        @(negedge wclk);
        wdata = 8'hAA;
        @(posedge wclk);
        #1;
        winc = 1'b0;
        check("ovf_set", 32'(woverflow), 32'(ERR));
        check("ovf_wlevel", 32'(wlevel), 32'(5'd16));
        repeat (2) @(negedge wclk);
        check("ovf_sticky", 32'(woverflow), 32'(ERR));
        @(negedge wclk);
        winc = 1'b1; wclr_err = 1'b1;
        @(posedge wclk);
        #1;
        winc = 1'b0;
        check("ovf_set_beats_clear", 32'(woverflow), 32'(ERR));
        @(posedge wclk);
        #1;
        wclr_err = 1'b0;
        check("ovf_cleared", 32'(woverflow), 32'(1'b0));

        // Drain.
        wait_rlevel("drain_start_rlevel", 16, 20);
        for (int i = 0; i < 16; i++) begin
            @(negedge rclk);
            rinc = 1'b1;
            @(posedge rclk);
            #1;
            check("drain_rdata", 32'(rdata), 32'(8'(i)));
            check("drain_rvalid", 32'(rvalid), 32'(1'b1));
            if (i >= 12) check("drain_ralmost_empty", 32'(ralmost_empty), 32'(i >= 13));
            if (i >= 14) check("drain_rempty", 32'(rempty), 32'(i == 15));
        end
        check("drain_rlevel", 32'(rlevel), 32'(5'd0));
        @(posedge rclk);
        #1;
        rinc = 1'b0;
        check("udf_rvalid", 32'(rvalid), 32'(1'b0));
        check("udf_rdata_hold", 32'(rdata), 32'(8'h0F));
        check("udf_set", 32'(runderflow), 32'(ERR));
        @(negedge rclk);
        rclr_err = 1'b1;
        @(posedge rclk);
        #1;
        rclr_err = 1'b0;
        check("udf_cleared", 32'(runderflow), 32'(1'b0));

        // Mid-operation reset discards stored words.
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            wdata = 8'(8'h80 + i); winc = 1'b1;
        end
        @(negedge wclk);
        winc = 1'b0;
        wait_rlevel("mid_pre_rlevel", 5, 20);
        #3;
        rrst_n = 1'b0;
        #1;
        check("mid_rlevel", 32'(rlevel), 32'(5'd0));
        check("mid_rempty", 32'(rempty), 32'(1'b1));
        check("mid_ralmost_empty", 32'(ralmost_empty), 32'(1'b1));
        check("mid_wlevel", 32'(wlevel), 32'(5'd0));
        check("mid_rdata", 32'(rdata), 32'(8'h00));
        repeat (3) @(negedge wclk);
        rrst_n = 1'b1;
        repeat (5) @(negedge wclk);
        repeat (5) @(negedge rclk);
        check("mid_post_rempty", 32'(rempty), 32'(1'b1));
        @(negedge wclk);
        wdata = 8'h55; winc = 1'b1;
        @(negedge wclk);
        winc = 1'b0;
        wait_rlevel("mid_new_rlevel", 1, 20);
        @(negedge rclk);
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
        check("mid_first_rdata", 32'(rdata), 32'(8'h55));
        check("mid_first_rvalid", 32'(rvalid), 32'(1'b1));

        // Randomised traffic across unrelated clocks, both ratios.
        wper = 10; rper = 17;
        run_random(100);
        wper = 17; rper = 10;
        run_random(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/async_fifo_lvl.md
Name: async_fifo_lvl

Overview:
Parametrised dual-clock FIFO for crossing data words from the wclk domain to the rclk domain. Uses Gray-coded pointers with N-stage synchronisers and a single shared reset with per-domain reset synchronisers. Compared with the existing FIFO it adds:
- fill-level outputs in each domain
- programmable almost-full and almost-empty thresholds
- registered read data with a valid strobe
- optional sticky overflow/underflow error flags

It is the standard CDC buffer for new datapaths.

Parameters:
DSIZE, 8, data word width
ASIZE, 4, address width; depth = 2**ASIZE
SYNC_STAGES, 2, synchroniser flops per crossing; legal range >= 2
AFULL_TH, (2**ASIZE)-2, walmost_full asserts when wlevel >= AFULL_TH
AEMPTY_TH, 2, ralmost_empty asserts when rlevel <= AEMPTY_TH

Ports:
wclk  in  1  write clock
rclk  in  1  read clock
rrst_n  in  1  reset, asynchronous, active-low; applies to both domains
wdata  in  DSIZE  write data
winc  in  1  write request
wfull  out  1  FIFO full (wclk domain)
walmost_full  out  1  level >= AFULL_TH (wclk domain)
wlevel  out  ASIZE+1  occupancy seen from the write side
wclr_err  in  1  clears woverflow
woverflow  out  1  sticky overflow flag
rinc  in  1  read request
rdata  out  DSIZE  registered read data
rvalid  out  1  rdata valid strobe
rempty  out  1  FIFO empty (rclk domain)
ralmost_empty  out  1  level <= AEMPTY_TH (rclk domain)
rlevel  out  ASIZE+1  occupancy seen from the read side
rclr_err  in  1  clears runderflow
runderflow  out  1  sticky underflow flag

Behaviour:
- Reset: rrst_n is asynchronous and active-low; the block's primary clock is wclk.
  - Assertion immediately resets both domains.
  - Deassertion passes through a SYNC_STAGES-flop synchroniser per domain (wclk and rclk) before that domain leaves reset.
  - Requests in a domain still held in reset are ignored.
- Reset values: wfull=0, walmost_full=0, wlevel=0, woverflow=0, rempty=1, ralmost_empty=1, rlevel=0, rdata=0, rvalid=0, runderflow=0. All pointers are 0.
- Memory is not reset. Reset mid-operation discards all stored words.
- Pointers: ASIZE+1-bit binary and Gray copies; they wrap modulo 2**(ASIZE+1). Address = low ASIZE bits of the binary pointer.
- Write: on a wclk edge with winc=1 and wfull=0, mem[waddr] <= wdata and the write pointer increments. winc=1 with wfull=1 is dropped; memory and pointer are unchanged.
- Read: on an rclk edge with rinc=1 and rempty=0, rdata <= mem[raddr], the read pointer increments, and rvalid <= 1. Otherwise rvalid <= 0 and rdata holds its value. Read latency is 1 rclk.
- Flags: wfull and rempty are registered from next-state pointers compared against synchronised Gray pointers.
  - Full: top two bits inverted, remaining bits equal.
  - Empty: all bits equal.
  - Both flags are conservative: they may deassert late, never early.
- Levels: wlevel <= wbin_next - gray2bin(wq_rptr); rlevel <= gray2bin(rq_wptr) - rbin_next. Arithmetic is ASIZE+1-bit modulo. Range 0..2**ASIZE.
- Almost flags are registered from the same next-state levels.
- Crossing latency: after a write-pointer update, rempty falls no earlier than SYNC_STAGES+1 rclk edges later. The full-release path is symmetric.
- Simultaneous read and write at full or empty: each side acts on its own registered flag only.

Optional Feature:
ASYNC_FIFO_ERR_EN
- Defined:
  - woverflow sets on a dropped write (winc & wfull).
  - runderflow sets on rinc & rempty.
  - Each flag clears on its clr input. Set wins over a same-cycle clear.
- Undefined: woverflow and runderflow are tied to 0, wclr_err and rclr_err are unused, and no error logic is generated.

Decomposition:
- Package async_fifo_pkg holds:
  - bin2gray and gray2bin functions, parametrised by width
  - the default SYNC_STAGES constant
  - the level-computation function
- One sub-module, afifo_sync_n: an N-stage synchroniser with async reset. It is instantiated for both pointer crossings and both reset-deassert synchronisers (din tied 1).

Test Plan:
All scenarios use DSIZE=8, ASIZE=4, SYNC_STAGES=2, AFULL_TH=14, AEMPTY_TH=2, and run with ASYNC_FIFO_ERR_EN defined unless stated.
1. Reset: hold rrst_n=0 with both clocks running -> every output equals its reset value; winc pulses before the sync release are ignored (wlevel stays 0).
2. Fill: 16 back-to-back writes of 0x00..0x0F -> walmost_full=1 after the 14th write edge, wfull=1 after the 16th, wlevel=16. A 17th write of 0xAA is dropped and woverflow=1 until wclr_err.
3. Drain: read 16 words -> rdata=0x00..0x0F in order, each with rvalid=1 one rclk after the accepted rinc; ralmost_empty=1 at rlevel<=2; rempty=1 after the 16th read. An extra rinc gives rvalid=0 and runderflow=1.
4. Wrap/CDC: wclk 10 ns, rclk 17 ns, 100 random words with random winc/rinc -> order preserved, no loss or duplication, pointers wrap past 31; repeat with the clock periods swapped.
5. Mid-operation reset: 5 words stored, rrst_n=0 for 3 cycles -> flags reset immediately, rlevel=0, rempty=1. After release, write 0x55 and read it back as the first rdata.
6. Latency: equal 10 ns clocks, single write 0x3C -> rempty falls on the 3rd rclk edge after the write edge, rlevel=1; the read returns 0x3C with rvalid one cycle later.
